ldpc_iter_ctrl: RTL
===================

Name: ldpc_iter_ctrl

Overview:
Synchronous iteration scheduler for the 6-VN / 3-CN flooding LDPC decoder datapath. It accepts a codeword job via valid/ready and pulses load and latch enables to the message registers in a fixed order: LOAD, CHECK, CN, CHECK, VN, CN, CHECK, and so on. It samples the parity-check result once per iteration and returns a status/iteration report via valid/ready. The decoder's toggle-derived latch clock is replaced by single-cycle enables on clk.

Parameters:
ITER_W, 8, width of max_iter and iter_count.
CN_LAT, 1, cycles the CN combinational path needs (>=1); the CN phase lasts CN_LAT cycles.
VN_LAT, 1, cycles the VN combinational path needs (>=1); the VN phase lasts VN_LAT cycles.

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
in_valid  in  1  job request; LLRs are stable on the datapath input while in_valid is high.
in_ready  out  1  high only in IDLE.
max_iter  in  ITER_W  iteration limit, captured on accept.
load_en  out  1  pulse: load channel LLRs into all vn->cn message registers.
cn_latch_en  out  1  pulse: latch CN outputs into the cn->vn registers.
vn_latch_en  out  1  pulse: latch VN outputs into the vn->cn registers.
hd_sel  out  1  hard-decision source: 0 = channel LLRs, 1 = posterior beliefs.
syndrome_ok  in  1  combinational H*c^T == 0 of the current hard decision.
busy  out  1  high in every state except IDLE.
out_valid  out  1  report valid; high only in DONE.
out_ready  in  1  report consumer ready.
status  out  2  00 none, 01 converged, 10 max iterations reached.
iter_count  out  ITER_W  completed iterations (number of cn_latch_en pulses in the job).

Behaviour:
- Reset: the state goes to IDLE. Outputs: in_ready=1; busy=0; out_valid=0; all enables=0; hd_sel=0; status=00; iter_count=0; the captured max_iter register is 0.
- Reset applies in any state and aborts a job in flight. No enable is pulsed in the reset cycle or in the cycle after it.
- Enables are registered one-hot decodes: at most one of load_en, cn_latch_en, vn_latch_en is high in any cycle, each for exactly one cycle.
- IDLE: in_ready=1. On in_valid=1: capture max_iter, clear status and iter_count, go to LOAD.
- LOAD (1 cycle): load_en=1; go to CHECK.
- CHECK (1 cycle): hd_sel = (iter_count != 0). Sample syndrome_ok in this cycle only:
  - ok: status<=01, go to DONE.
  - else if iter_count >= max_iter_q: status<=10, go to DONE.
  - else if iter_count == 0: go to CN.
  - else: go to VN.
- CN: stay CN_LAT cycles using a down-counter. cn_latch_en=1 in the last cycle. iter_count increments on that same edge. Then go to CHECK.
- VN: stay VN_LAT cycles. vn_latch_en=1 in the last cycle. Then go to CN.
- DONE: out_valid=1; status and iter_count are held. On out_ready=1, go to IDLE. A new job can be accepted no earlier than the cycle after the handshake. status and iter_count keep their values in IDLE until the next accept.
- max_iter=0: only the channel-LLR check runs. Result is status 01 or 10 with iter_count=0.
- iter_count cannot exceed max_iter_q, so it never wraps.
- Latency with CN_LAT=VN_LAT=1, accept edge = cycle 0:
  - Converged on the channel LLRs: out_valid in cycle 3.
  - Each extra iteration adds 2 cycles for the first iteration and 3 cycles (VN+CN+CHECK) for each later one.
- in_valid and out_ready are ignored outside IDLE and DONE respectively.
- hd_sel keeps its CHECK value through DONE, so the hard-decision result stays aligned with the report.

Decomposition:
- ldpc_pkg holds:
  - the state enum (IDLE, LOAD, CHECK, CN, VN, DONE);
  - the status constants ST_NONE=2'b00, ST_CONV=2'b01, ST_MAXIT=2'b10;
  - the default ITER_W.
- One sub-module, ldpc_phase_timer: loadable down-counter with a last-cycle flag, instantiated once and shared by the CN and VN phases.

Test Plan:
- Reset, then in_valid with max_iter=5 and syndrome_ok=1 held: load_en in cycle 1, out_valid in cycle 3, status=01, iter_count=0, no cn_latch_en or vn_latch_en.
- max_iter=2, syndrome_ok=0 always: cycle 2 CHECK, cycle 3 cn_latch_en, cycle 5 vn_latch_en, cycle 6 cn_latch_en, cycle 8 out_valid with status=10 and iter_count=2.
- syndrome_ok goes to 1 only in the third CHECK: status=01, iter_count=2, hd_sel=1 in DONE.
- CN_LAT=3, VN_LAT=2, max_iter=1, syndrome_ok=0: cn_latch_en at the end of 3 CN cycles, no vn_latch_en, status=10, iter_count=1.
- out_ready held low for 10 cycles in DONE: out_valid and status held, in_ready=0, a new in_valid is ignored. Release: IDLE the next cycle.
- rst asserted during the VN phase: IDLE next cycle, all outputs at reset values, no latch pulse. A new job then runs normally.

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared types and constants for the LDPC iteration scheduler.
package ldpc_pkg;

  localparam int ITER_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    CN,
    VN,
    DONE
  } state_e;

  localparam logic [1:0] ST_NONE  = 2'b00;
  localparam logic [1:0] ST_CONV  = 2'b01;
  localparam logic [1:0] ST_MAXIT = 2'b10;

endpackage

// File: rtl/ldpc_phase_timer.sv
// Loadable down-counter shared by the CN and VN phases. last flags the final
// cycle of a phase; last_next predicts it for the coming cycle so the caller
// can register its latch enables.
module ldpc_phase_timer
  import ldpc_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last,
  output logic         last_next
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority; decrement saturates at the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last      = (cnt_q == '0);
  assign last_next = (cnt_d == '0);

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// Iteration scheduler for the 6-VN / 3-CN flooding LDPC datapath.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a job; in_ready high
// LOAD  | load_en pulse: channel LLRs into vn->cn registers
// CHECK | sample syndrome_ok once; decide converge / give up / iterate
// CN    | CN_LAT cycles; cn_latch_en in the last one, iteration counted
// VN    | VN_LAT cycles; vn_latch_en in the last one
// DONE  | report held on out_valid until out_ready
module ldpc_iter_ctrl
  import ldpc_pkg::*;
#(
  parameter int ITER_W = ITER_W_DEF,
  parameter int CN_LAT = 1,
  parameter int VN_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ITER_W-1:0] max_iter,
  output logic              load_en,
  output logic              cn_latch_en,
  output logic              vn_latch_en,
  output logic              hd_sel,
  input  logic              syndrome_ok,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        status,
  output logic [ITER_W-1:0] iter_count
);

  localparam int LAT_MAX = (CN_LAT > VN_LAT) ? CN_LAT : VN_LAT;
  localparam int TMR_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam logic [TMR_W-1:0] CN_LOAD = TMR_W'(CN_LAT - 1);
  localparam logic [TMR_W-1:0] VN_LOAD = TMR_W'(VN_LAT - 1);

  state_e              state_q, state_d;
  logic [ITER_W-1:0]   max_iter_q, max_iter_d;
  logic [ITER_W-1:0]   iter_count_q, iter_count_d;
  logic [1:0]          status_q, status_d;
  logic                load_en_q, load_en_d;
  logic                cn_latch_en_q, cn_latch_en_d;
  logic                vn_latch_en_q, vn_latch_en_d;
  logic                hd_sel_q, hd_sel_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                out_valid_q, out_valid_d;

  logic                tmr_load;
  logic [TMR_W-1:0]    tmr_val;
  logic                tmr_dec;
  logic                tmr_last;
  logic                tmr_last_next;

  ldpc_phase_timer #(.W(TMR_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .dec       (tmr_dec),
    .last      (tmr_last),
    .last_next (tmr_last_next)
  );

  // Next state, job registers and phase timer control.
  always_comb begin
    state_d      = state_q;
    max_iter_d   = max_iter_q;
    iter_count_d = iter_count_q;
    status_d     = status_q;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    tmr_dec      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          max_iter_d   = max_iter;
          iter_count_d = '0;
          status_d     = ST_NONE;
          state_d      = LOAD;
        end
      end
      LOAD: state_d = CHECK;
      CHECK: begin
        if (syndrome_ok) begin
          status_d = ST_CONV;
          state_d  = DONE;
        end else if (iter_count_q >= max_iter_q) begin
          status_d = ST_MAXIT;
          state_d  = DONE;
        end else if (iter_count_q == '0) begin
          tmr_load = 1'b1;
          tmr_val  = CN_LOAD;
          state_d  = CN;
        end else begin
          tmr_load = 1'b1;
          tmr_val  = VN_LOAD;
          state_d  = VN;
        end
      end
      CN: begin
        if (tmr_last) begin
          iter_count_d = iter_count_q + ITER_W'(1);
          state_d      = CHECK;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      VN: begin
        if (tmr_last) begin
          tmr_load = 1'b1;
          tmr_val  = CN_LOAD;
          state_d  = CN;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered output decodes of the coming state; hd_sel follows the
  // iteration count when entering CHECK and is otherwise held into DONE.
  always_comb begin
    load_en_d     = (state_d == LOAD);
    cn_latch_en_d = (state_d == CN) && tmr_last_next;
    vn_latch_en_d = (state_d == VN) && tmr_last_next;
    in_ready_d    = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
    out_valid_d   = (state_d == DONE);
    hd_sel_d      = hd_sel_q;
    if (state_d == LOAD) hd_sel_d = 1'b0;
    if (state_d == CHECK) hd_sel_d = (iter_count_d != '0);
  end

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      max_iter_q    <= '0;
      iter_count_q  <= '0;
      status_q      <= ST_NONE;
      load_en_q     <= 1'b0;
      cn_latch_en_q <= 1'b0;
      vn_latch_en_q <= 1'b0;
      hd_sel_q      <= 1'b0;
      in_ready_q    <= 1'b1;
      busy_q        <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      max_iter_q    <= max_iter_d;
      iter_count_q  <= iter_count_d;
      status_q      <= status_d;
      load_en_q     <= load_en_d;
      cn_latch_en_q <= cn_latch_en_d;
      vn_latch_en_q <= vn_latch_en_d;
      hd_sel_q      <= hd_sel_d;
      in_ready_q    <= in_ready_d;
      busy_q        <= busy_d;
      out_valid_q   <= out_valid_d;
    end
  end

  // An enable already registered for the cycle in which reset is sampled
  // must not reach the message registers, so the enables are masked by rst.
  assign load_en     = load_en_q & ~rst;
  assign cn_latch_en = cn_latch_en_q & ~rst;
  assign vn_latch_en = vn_latch_en_q & ~rst;
  assign hd_sel      = hd_sel_q;
  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign out_valid   = out_valid_q;
  assign status      = status_q;
  assign iter_count  = iter_count_q;

endmodule
